ysyx_040066_intr_ctrl: RTL

//   Machine-mode trap/interrupt controller downstream of the CLINT. Consumes
//   the CLINT timer-interrupt level plus ecall/mret from the commit (WB)

---
 rtl/ysyx_040066_intr_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ysyx_040066_intr_ctrl.sv
// Machine-mode trap/interrupt controller: owns mstatus/mie/mip/mtvec/mepc/mcause,
// takes timer interrupts, ecall and mret at commit, and issues a registered redirect.
module ysyx_040066_intr_ctrl #(
   parameter logic [63:0] MTVEC_RST   = 64'h0000_0000_8000_0000,
   parameter logic [63:0] MSTATUS_RST = 64'h0000_0000_0000_1800
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_timer_intr,
   input  logic        i_commit_valid,
   input  logic [63:0] i_commit_pc,
   input  logic        i_commit_ecall,
   input  logic        i_commit_mret,
   input  logic        i_csr_en,
   input  logic [1:0]  i_csr_op,
   input  logic [11:0] i_csr_addr,
   input  logic [63:0] i_csr_wdata,
   output logic [63:0] o_csr_rdata,
   output logic        o_csr_err,
   output logic        o_redirect_valid,
   output logic [63:0] o_redirect_pc,
   output logic        o_dbg_state
);

   typedef enum logic {ST_RUN = 1'b0, ST_REDIR = 1'b1} state_t;

   localparam logic [63:0] CAUSE_MTI   = 64'h8000_0000_0000_0007;
   localparam logic [63:0] CAUSE_ECALL = 64'd11;

   state_t      r_state, w_next_state;
   logic        r_mstatus_mie, r_mstatus_mpie, r_mie_mtie, r_mtip;
   logic [63:0] r_mtvec, r_mepc, r_mcause;

   logic        w_accept, w_pending, w_take_int, w_take_ecall, w_take_mret, w_do_csr;
   logic        w_csr_hit, w_csr_wr;
   logic [63:0] w_csr_old, w_csr_new, w_mstatus_rd, w_base, w_int_tgt;

   assign o_dbg_state = r_state;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_RUN;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = ST_RUN;
      if (r_state == ST_RUN && (w_take_int || w_take_ecall || w_take_mret))
         w_next_state = ST_REDIR;
   end

   // Commit decode; the REDIR cycle ignores commit because that instruction was flushed.
   always_comb begin
      w_accept     = (r_state == ST_RUN) && i_commit_valid;
      w_pending    = r_mtip && r_mie_mtie && r_mstatus_mie;
      w_take_int   = w_accept && w_pending;
      w_take_ecall = w_accept && !w_pending && i_commit_ecall;
      w_take_mret  = w_accept && !w_pending && !i_commit_ecall && i_commit_mret;
      w_do_csr     = w_accept && !w_pending && !i_commit_ecall && !i_commit_mret && i_csr_en;
   end

   // MPP is hardwired to machine mode, so only MIE/MPIE carry state.
   assign w_mstatus_rd = {51'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
   assign w_base       = {r_mtvec[63:2], 2'b00};
   assign w_int_tgt    = (r_mtvec[1:0] == 2'b01) ? (w_base + 64'd28) : w_base;

   always_comb begin
      w_csr_hit = 1'b1;
      w_csr_old = 64'd0;
      case (i_csr_addr)
         12'h300: w_csr_old = w_mstatus_rd;
         12'h304: w_csr_old = {56'd0, r_mie_mtie, 7'd0};
         12'h305: w_csr_old = r_mtvec;
         12'h341: w_csr_old = r_mepc;
         12'h342: w_csr_old = r_mcause;
         12'h344: w_csr_old = {56'd0, r_mtip, 7'd0};
         default: w_csr_hit = 1'b0;
      endcase
   end

   always_comb begin
      w_csr_new = w_csr_old;
      case (i_csr_op)
         2'b01:   w_csr_new = i_csr_wdata;
         2'b10:   w_csr_new = w_csr_old | i_csr_wdata;
         2'b11:   w_csr_new = w_csr_old & ~i_csr_wdata;
         default: w_csr_new = w_csr_old;
      endcase
      w_csr_wr = w_do_csr && w_csr_hit &&
                 ((i_csr_op == 2'b01) || (i_csr_op[1] && (i_csr_wdata != 64'd0)));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mstatus_mie    <= MSTATUS_RST[3];
         r_mstatus_mpie   <= MSTATUS_RST[7];
         r_mie_mtie       <= 1'b0;
         r_mtip           <= 1'b0;
         r_mtvec          <= MTVEC_RST;
         r_mepc           <= 64'd0;
         r_mcause         <= 64'd0;
         o_csr_rdata      <= 64'd0;
         o_csr_err        <= 1'b0;
         o_redirect_valid <= 1'b0;
         o_redirect_pc    <= 64'd0;
      end else begin
         r_mtip           <= i_timer_intr;
         o_csr_err        <= 1'b0;
         o_redirect_valid <= 1'b0;
         if (w_take_int || w_take_ecall) begin
            r_mepc           <= {i_commit_pc[63:2], 2'b00};
            r_mcause         <= w_take_int ? CAUSE_MTI : CAUSE_ECALL;
            r_mstatus_mpie   <= r_mstatus_mie;
            r_mstatus_mie    <= 1'b0;
            o_redirect_valid <= 1'b1;
            o_redirect_pc    <= w_take_int ? w_int_tgt : w_base;
         end else if (w_take_mret) begin
            r_mstatus_mie    <= r_mstatus_mpie;
            r_mstatus_mpie   <= 1'b1;
            o_redirect_valid <= 1'b1;
            o_redirect_pc    <= r_mepc;
         end else if (w_do_csr) begin
            o_csr_rdata <= w_csr_old;
            o_csr_err   <= !w_csr_hit;
            if (w_csr_wr) begin
               case (i_csr_addr)
                  12'h300: begin
                     r_mstatus_mie  <= w_csr_new[3];
                     r_mstatus_mpie <= w_csr_new[7];
                  end
                  12'h304: r_mie_mtie <= w_csr_new[7];
                  12'h305: r_mtvec    <= w_csr_new;
                  12'h341: r_mepc     <= {w_csr_new[63:2], 2'b00};
                  12'h342: r_mcause   <= w_csr_new;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
